instr_sequencer: RTL and testbench

- Feeds a stored instruction sequence to `simple_processor` one instruction at a time, replacing hand-driven `run`/`DIN` stimulus.
- Holds a small loadable program memory of 16-bit instruction words.
- For each instruction it presents the word on `DIN`, pulses `run`, waits for the processor's `done`, then advances.
- Sits between a loader/host and the processor's `run`, `DIN` and `done` ports; a watchdog flags a processor that never completes.

---
 rtl/instr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Feeds a stored program of 16-bit instruction words to
//             simple_processor, one instruction at a time: present the word
//             on DIN, pulse run, wait for done, advance. A watchdog aborts
//             the run if the processor never answers.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH        program memory words (must equal 2**AW)
//    AW           program address width
//    DONE_TIMEOUT WAIT cycles without done before the watchdog fires (1..255)
//  Ports
//    clk_50MHz    in   system clock, rising edge
//    reset_n      in   asynchronous active-low reset
//    prog_we      in   program write strobe (IDLE only)
//    prog_addr    in   program write address [AW]
//    prog_data    in   instruction word to write [16]
//    prog_len     in   instructions to run, 0..DEPTH [AW+1]
//    start        in   start request (IDLE only)
//    halt         in   stop request, sampled between instructions
//    done         in   instruction complete, from the processor
//    run          out  one-cycle issue strobe
//    DIN          out  instruction word to the processor [16]
//    pc           out  index of the current instruction [AW]
//    busy         out  high in every state except IDLE
//    finished     out  one-cycle pulse at normal end of a sequence
//    timeout_err  out  sticky watchdog flag
//  Build option
//    INSTR_SEQ_LOOP_EN  when defined, the program repeats until halt,
//                       watchdog timeout or reset.
// ============================================================================
module instr_sequencer #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          halt,
  input  logic          done,
  output logic          run,
  output logic [15:0]   DIN,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err
);

  localparam logic [7:0] C_TIMEOUT = 8'(DONE_TIMEOUT);
  localparam logic [AW:0] C_LEN_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          finished_q, finished_d;
  logic          mem_we;
  logic [AW:0]   last_idx;
  logic          is_last;

  logic [15:0]   mem [DEPTH];

  // Compare done at AW+1 bits so prog_len == DEPTH ends at pc == DEPTH-1.
  assign last_idx = len_q - C_LEN_ONE;
  assign is_last  = ({1'b0, pc_q} == last_idx);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    finished_d = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start wins over a same-cycle write; the write is dropped.
        if (start) begin
          if (prog_len != '0) begin
            len_d     = prog_len;
            pc_d      = '0;
            timeout_d = 1'b0;
            state_d   = S_ISSUE;
          end else begin
            finished_d = 1'b1;
          end
        end else if (prog_we) begin
          mem_we = 1'b1;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (done) begin
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == C_TIMEOUT) begin
            timeout_d = 1'b1;
            pc_d      = '0;
            state_d   = S_IDLE;
          end
        end
      end

      S_NEXT: begin
        if (halt) begin
          finished_d = 1'b1;
          pc_d       = '0;
          state_d    = S_IDLE;
        end
`ifdef INSTR_SEQ_LOOP_EN
        else if (is_last) begin
          pc_d    = '0;
          state_d = S_ISSUE;
        end
`else
        else if (is_last) begin
          finished_d = 1'b1;
          pc_d       = '0;
          state_d    = S_IDLE;
        end
`endif
        else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      finished_q <= finished_d;
    end
  end

  // Program store: no reset, contents survive across runs.
  always_ff @(posedge clk_50MHz) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Outputs decode from registered state, so an asynchronous reset drops
  // run and DIN immediately.
  assign run         = (state_q == S_ISSUE);
  assign DIN         = (state_q == S_IDLE) ? 16'h0000 : mem[pc_q];
  assign pc          = pc_q;
  assign busy        = (state_q != S_IDLE);
  assign finished    = finished_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Directed self-checking bench for instr_sequencer with a
//             simple processor model answering done a fixed delay after run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int AW = 4;

  logic          clk_50MHz = 1'b0;
  logic          reset_n   = 1'b0;
  logic          prog_we   = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW:0]   prog_len  = '0;
  logic          start     = 1'b0;
  logic          halt      = 1'b0;
  logic          done      = 1'b0;
  logic          run;
  logic [15:0]   DIN;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic          timeout_err;

  int checks = 0;
  int fails  = 0;

  logic [15:0] seen [16];
  int n_run, n_fin, min_gap;

  instr_sequencer #(.DEPTH(16), .AW(AW), .DONE_TIMEOUT(8)) dut (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .start      (start),
    .halt       (halt),
    .done       (done),
    .run        (run),
    .DIN        (DIN),
    .pc         (pc),
    .busy       (busy),
    .finished   (finished),
    .timeout_err(timeout_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] len);
    start = 1'b1; prog_len = len;
    tick();
    start = 1'b0;
  endtask

  // Processor model / observer. Runs a fixed window of cycles, records every
  // issued word, answers done done_dly cycles after run (0 = never), raises
  // halt once halt_runs instructions have been issued, and optionally tries
  // a program write at window cycle 1.
  task automatic exec(input int ncyc, input int done_dly, input int halt_runs,
                      input bit try_write);
    int last, done_at;
    n_run = 0; n_fin = 0; min_gap = 1000; last = -1000; done_at = -1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (run) begin
        if (n_run < 16) seen[n_run] = DIN;
        if (cyc - last < min_gap) min_gap = cyc - last;
        last = cyc;
        n_run++;
        done_at = (done_dly > 0) ? cyc + done_dly : -1;
      end
      if (finished) n_fin++;
      done = (cyc == done_at);
      if (halt_runs > 0 && n_run >= halt_runs && !run) halt = 1'b1;
      if (try_write && cyc == 1) begin
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'hDEAD;
      end else begin
        prog_we = 1'b0;
      end
      tick();
    end
    done = 1'b0; halt = 1'b0; prog_we = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    checks++; if (run !== 1'b0)   begin fails++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if (DIN !== 16'h0)  begin fails++; $display("FAIL reset_din got=%h exp=0000", DIN); end
    checks++; if (pc !== '0)      begin fails++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (finished !== 1'b0 || timeout_err !== 1'b0)
      begin fails++; $display("FAIL reset_flags got=%b%b exp=00", finished, timeout_err); end
    tick(); reset_n = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_zero_len();
    do_start('0);
    checks++; if (finished !== 1'b1 || busy !== 1'b0 || run !== 1'b0)
      begin fails++; $display("FAIL zero_len fin/busy/run got=%b%b%b exp=100", finished, busy, run); end
    tick();
    checks++; if (finished !== 1'b0) begin fails++; $display("FAIL zero_len_pulse got=%b exp=0", finished); end
  endtask

  task automatic test_single();
    load(0, 16'h101C);
    do_start(5'd1);
    checks++; if (run !== 1'b1 || DIN !== 16'h101C)
      begin fails++; $display("FAIL single_issue run=%b din=%h exp 1/101C", run, DIN); end
    exec(12, 2, 0, 1'b0);
    checks++; if (n_run !== 1) begin fails++; $display("FAIL single_runs got=%0d exp=1", n_run); end
    checks++; if (n_fin !== 1) begin fails++; $display("FAIL single_fin got=%0d exp=1", n_fin); end
    checks++; if (busy !== 1'b0 || pc !== '0 || DIN !== 16'h0)
      begin fails++; $display("FAIL single_end busy=%b pc=%0d din=%h exp 0/0/0000", busy, pc, DIN); end
  endtask

  task automatic test_three();
    load(0, 16'h101C); load(1, 16'h0200); load(2, 16'h32FF);
    do_start(5'd3);
    exec(20, 2, 0, 1'b0);
    checks++; if (n_run !== 3) begin fails++; $display("FAIL three_runs got=%0d exp=3", n_run); end
    checks++; if (seen[0] !== 16'h101C || seen[1] !== 16'h0200 || seen[2] !== 16'h32FF)
      begin fails++; $display("FAIL three_din got=%h,%h,%h exp=101C,0200,32FF", seen[0], seen[1], seen[2]); end
    checks++; if (min_gap !== 4) begin fails++; $display("FAIL three_gap got=%0d exp=4", min_gap); end
    checks++; if (n_fin !== 1) begin fails++; $display("FAIL three_fin got=%0d exp=1", n_fin); end
  endtask

  task automatic test_back_to_back();
    do_start(5'd3);
    exec(16, 1, 0, 1'b0);
    checks++; if (n_run !== 3 || min_gap !== 3)
      begin fails++; $display("FAIL b2b runs=%0d gap=%0d exp 3/3", n_run, min_gap); end
    checks++; if (n_fin !== 1) begin fails++; $display("FAIL b2b_fin got=%0d exp=1", n_fin); end
  endtask

  task automatic test_watchdog();
    do_start(5'd1);
    exec(8, 0, 0, 1'b0);  // ISSUE + WAIT cycles 1..7, now in 8th WAIT cycle
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("FAIL wd_early to=%b busy=%b exp 0/1", timeout_err, busy); end
    tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || pc !== '0)
      begin fails++; $display("FAIL wd_fire to=%b busy=%b pc=%0d exp 1/0/0", timeout_err, busy, pc); end
    checks++; if (n_fin !== 0 || finished !== 1'b0)
      begin fails++; $display("FAIL wd_nofin got=%0d/%b exp=0/0", n_fin, finished); end
    do_start(5'd1);
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL wd_clear got=%b exp=0", timeout_err); end
    exec(10, 2, 0, 1'b0);
  endtask

  task automatic test_halt_dropped_write();
    load(3, 16'h4ABC);
    do_start(5'd4);
    exec(20, 2, 2, 1'b1);
    checks++; if (n_run !== 2) begin fails++; $display("FAIL halt_runs got=%0d exp=2", n_run); end
    checks++; if (n_fin !== 1) begin fails++; $display("FAIL halt_fin got=%0d exp=1", n_fin); end
    do_start(5'd1);
    checks++; if (DIN !== 16'h101C) begin fails++; $display("FAIL dropped_write got=%h exp=101C", DIN); end
    exec(10, 2, 0, 1'b0);
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 16; i++) load(i[AW-1:0], 16'h1000 + 16'(i));
    do_start(5'd16);
    exec(80, 1, 0, 1'b0);
    checks++; if (n_run !== 16 || n_fin !== 1)
      begin fails++; $display("FAIL depth runs=%0d fin=%0d exp 16/1", n_run, n_fin); end
    checks++; if (seen[15] !== 16'h100F || seen[0] !== 16'h1000)
      begin fails++; $display("FAIL depth_din got=%h/%h exp=1000/100F", seen[0], seen[15]); end
    checks++; if (pc !== '0 || busy !== 1'b0)
      begin fails++; $display("FAIL depth_end pc=%0d busy=%b exp 0/0", pc, busy); end
  endtask

  task automatic test_reset_mid_wait();
    do_start(5'd3);
    tick();  // WAIT
    #4 reset_n = 1'b0;
    #1;
    checks++; if (run !== 1'b0 || DIN !== 16'h0 || pc !== '0 || busy !== 1'b0 || finished !== 1'b0 || timeout_err !== 1'b0)
      begin fails++; $display("FAIL midreset run=%b din=%h pc=%0d busy=%b fin=%b to=%b exp all 0",
                              run, DIN, pc, busy, finished, timeout_err); end
    tick(); reset_n = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b exp=0", busy); end
  endtask

`ifdef INSTR_SEQ_LOOP_EN
  task automatic test_loop();
    load(0, 16'h101C); load(1, 16'h0200);
    do_start(5'd2);
    exec(20, 2, 0, 1'b0);
    checks++; if (n_run !== 5 || n_fin !== 0)
      begin fails++; $display("FAIL loop runs=%0d fin=%0d exp 5/0", n_run, n_fin); end
    checks++; if (seen[0] !== 16'h101C || seen[1] !== 16'h0200 || seen[2] !== 16'h101C || seen[3] !== 16'h0200)
      begin fails++; $display("FAIL loop_din got=%h,%h,%h,%h", seen[0], seen[1], seen[2], seen[3]); end
    exec(12, 2, 1, 1'b0);
    checks++; if (n_run !== 1 || n_fin !== 1 || busy !== 1'b0)
      begin fails++; $display("FAIL loop_halt runs=%0d fin=%0d busy=%b exp 1/1/0", n_run, n_fin, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_len();
    test_single();
    test_three();
    test_back_to_back();
    test_watchdog();
    test_halt_dropped_write();
    test_full_depth();
    test_reset_mid_wait();
`ifdef INSTR_SEQ_LOOP_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
